// File: rtl/peri_timer.sv
// peri_timer: machine timer peripheral on the on-chip peripheral bus.
// Holds a 64-bit mtime counter driven by a programmable prescaler, a 64-bit
// mtimecmp compare register and a registered, level-sensitive timer interrupt.
// Every request is granted immediately and answered with rvalid one cycle later.
module peri_timer #(
    parameter logic [15:0] PRESCALE_RST = 16'd0,
    parameter logic [63:0] CMP_RST      = 64'hFFFF_FFFF_FFFF_FFFF
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        peri_req,
    input  logic [31:0] peri_addr,
    input  logic        peri_write,
    input  logic [3:0]  peri_be,
    input  logic [31:0] peri_wdata,
    output logic        peri_gnt,
    output logic        peri_rvalid,
    output logic [31:0] peri_rdata,
    output logic        irq_timer_o
);

    localparam logic [2:0] OFF_MTIME_LO = 3'd0;
    localparam logic [2:0] OFF_MTIME_HI = 3'd1;
    localparam logic [2:0] OFF_CMP_LO   = 3'd2;
    localparam logic [2:0] OFF_CMP_HI   = 3'd3;
    localparam logic [2:0] OFF_CTRL     = 3'd4;
    localparam logic [2:0] OFF_PRESCALE = 3'd5;
    localparam logic [2:0] OFF_STATUS   = 3'd6;

    logic [63:0] mtime;
    logic [63:0] mtimecmp;
    logic [31:0] shadow_hi;
    logic [15:0] prescale;
    logic [15:0] presc_cnt;
    logic        ctrl_en;
    logic        ctrl_ie;

    logic [2:0]  offset;
    logic        wr_en;
    logic        rd_en;
    logic        wr_any_byte;
    logic        tick;
    logic        cmp_hit;
    logic [31:0] rd_value;

    // The decoder already qualified the window, so the remaining address bits are ignored.
    logic unused_addr;
    assign unused_addr = ^{peri_addr[31:5], peri_addr[1:0]};

    assign offset      = peri_addr[4:2];
    assign wr_en       = peri_req & peri_write;
    assign rd_en       = peri_req & ~peri_write;
    assign wr_any_byte = wr_en & (|peri_be);
    assign tick        = ctrl_en & (presc_cnt == prescale);
    assign cmp_hit     = (mtime >= mtimecmp);
    assign peri_gnt    = peri_req;

    // Merge the enabled bytes of the write data into an existing 32-bit word.
    function automatic logic [31:0] byte_merge(input logic [31:0] old_val,
                                               input logic [31:0] new_val,
                                               input logic [3:0]  be);
        logic [31:0] res;
        for (int i = 0; i < 4; i++) begin
            res[8*i +: 8] = be[i] ? new_val[8*i +: 8] : old_val[8*i +: 8];
        end
        return res;
    endfunction

    // Read mux; unmapped offsets and unused bits read as zero.
    always_comb begin
        rd_value = 32'd0;
        case (offset)
            OFF_MTIME_LO: rd_value = mtime[31:0];
            OFF_MTIME_HI: rd_value = shadow_hi;
            OFF_CMP_LO:   rd_value = mtimecmp[31:0];
            OFF_CMP_HI:   rd_value = mtimecmp[63:32];
            OFF_CTRL:     rd_value = {30'd0, ctrl_ie, ctrl_en};
            OFF_PRESCALE: rd_value = {16'd0, prescale};
            OFF_STATUS:   rd_value = {31'd0, cmp_hit};
            default:      rd_value = 32'd0;
        endcase
    end

    // Prescaler counter; a write that actually touches PRESCALE restarts it.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            presc_cnt <= 16'd0;
        end else if (wr_any_byte && offset == OFF_PRESCALE) begin
            presc_cnt <= 16'd0;
        end else if (ctrl_en) begin
            presc_cnt <= tick ? 16'd0 : presc_cnt + 16'd1;
        end
    end

    // mtime: a bus write to either half wins over the increment for that cycle.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mtime <= 64'd0;
        end else if (wr_any_byte && offset == OFF_MTIME_LO) begin
            mtime[31:0] <= byte_merge(mtime[31:0], peri_wdata, peri_be);
        end else if (wr_any_byte && offset == OFF_MTIME_HI) begin
            mtime[63:32] <= byte_merge(mtime[63:32], peri_wdata, peri_be);
        end else if (tick) begin
            mtime <= mtime + 64'd1;
        end
    end

    // Compare register, written one 32-bit half at a time.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mtimecmp <= CMP_RST;
        end else if (wr_en && offset == OFF_CMP_LO) begin
            mtimecmp[31:0] <= byte_merge(mtimecmp[31:0], peri_wdata, peri_be);
        end else if (wr_en && offset == OFF_CMP_HI) begin
            mtimecmp[63:32] <= byte_merge(mtimecmp[63:32], peri_wdata, peri_be);
        end
    end

    // Control and prescale configuration registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ctrl_en  <= 1'b0;
            ctrl_ie  <= 1'b0;
            prescale <= PRESCALE_RST;
        end else if (wr_en) begin
            if (offset == OFF_CTRL && peri_be[0]) begin
                ctrl_en <= peri_wdata[0];
                ctrl_ie <= peri_wdata[1];
            end
            if (offset == OFF_PRESCALE) begin
                if (peri_be[0]) prescale[7:0]  <= peri_wdata[7:0];
                if (peri_be[1]) prescale[15:8] <= peri_wdata[15:8];
            end
        end
    end

    // Reading MTIME_LO freezes the upper half so a LO/HI pair is coherent.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            shadow_hi <= 32'd0;
        end else if (rd_en && offset == OFF_MTIME_LO) begin
            shadow_hi <= mtime[63:32];
        end
    end

    // Bus response: rvalid follows each grant by one cycle, rdata is zero unless reading.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            peri_rvalid <= 1'b0;
            peri_rdata  <= 32'd0;
        end else begin
            peri_rvalid <= peri_req;
            peri_rdata  <= rd_en ? rd_value : 32'd0;
        end
    end

    // Level-sensitive interrupt, registered from the current compare result.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            irq_timer_o <= 1'b0;
        end else begin
            irq_timer_o <= ctrl_ie & cmp_hit;
        end
    end

endmodule

// File: tb/tb_peri_timer.sv
// tb_peri_timer: directed self-checking bench for peri_timer.
// Bus inputs change on the falling edge; outputs are sampled 1ns after the rising edge.
module tb_peri_timer;

    logic        clk;
    logic        rst_n;
    logic        peri_req;
    logic [31:0] peri_addr;
    logic        peri_write;
    logic [3:0]  peri_be;
    logic [31:0] peri_wdata;
    logic        peri_gnt;
    logic        peri_rvalid;
    logic [31:0] peri_rdata;
    logic        irq_timer_o;

    int n_checks;
    int n_fail;

    logic [31:0] rd;
    logic        g_seen;
    logic        v_seen;

    peri_timer dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .peri_req    (peri_req),
        .peri_addr   (peri_addr),
        .peri_write  (peri_write),
        .peri_be     (peri_be),
        .peri_wdata  (peri_wdata),
        .peri_gnt    (peri_gnt),
        .peri_rvalid (peri_rvalid),
        .peri_rdata  (peri_rdata),
        .irq_timer_o (irq_timer_o)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // One bus transfer; upper address bits are set to junk to show they are ignored.
    task automatic bus_op(input logic wr, input logic [2:0] off, input logic [3:0] be,
                          input logic [31:0] wd, output logic [31:0] rdat,
                          output logic gnt_s, output logic rv_s);
        @(negedge clk);
        peri_req   = 1'b1;
        peri_write = wr;
        peri_addr  = {24'h800000, 3'b101, off, 2'b10};
        peri_be    = be;
        peri_wdata = wd;
        #1 gnt_s = peri_gnt;
        @(posedge clk);
        #1;
        rv_s       = peri_rvalid;
        rdat       = peri_rdata;
        peri_req   = 1'b0;
        peri_write = 1'b0;
    endtask

    task automatic wr_reg(input logic [2:0] off, input logic [3:0] be, input logic [31:0] wd);
        logic [31:0] d;
        logic        a;
        logic        b;
        bus_op(1'b1, off, be, wd, d, a, b);
    endtask

    task automatic rd_reg(input logic [2:0] off, output logic [31:0] rdat);
        logic a;
        logic b;
        bus_op(1'b0, off, 4'h0, 32'h0, rdat, a, b);
    endtask

    task automatic test_reset;
        logic [31:0] exp;
        rst_n = 1'b0;
        peri_req = 1'b0; peri_write = 1'b0; peri_addr = 32'h0; peri_be = 4'h0; peri_wdata = 32'h0;
        #12;
        n_checks++;
        if (peri_rvalid !== 1'b0 || peri_rdata !== 32'h0 || irq_timer_o !== 1'b0 || peri_gnt !== 1'b0) begin
            n_fail++;
            $display("[TB] FAIL reset_outputs: got gnt=%b rvalid=%b rdata=%h irq=%b, want all 0",
                     peri_gnt, peri_rvalid, peri_rdata, irq_timer_o);
        end
        @(negedge clk);
        rst_n = 1'b1;
        for (int i = 0; i < 8; i++) begin
            exp = (i == 2 || i == 3) ? 32'hFFFF_FFFF : 32'h0;
            bus_op(1'b0, 3'(i), 4'h0, 32'h0, rd, g_seen, v_seen);
            n_checks++;
            if (rd !== exp || g_seen !== 1'b1 || v_seen !== 1'b1) begin
                n_fail++;
                $display("[TB] FAIL reset_read off=%0d: got rdata=%h gnt=%b rvalid=%b, want rdata=%h gnt=1 rvalid=1",
                         i, rd, g_seen, v_seen, exp);
            end
        end
        @(posedge clk);
        #1;
        n_checks++;
        if (peri_rvalid !== 1'b0 || irq_timer_o !== 1'b0) begin
            n_fail++;
            $display("[TB] FAIL reset_idle: got rvalid=%b irq=%b, want 0 0", peri_rvalid, irq_timer_o);
        end
    endtask

    task automatic test_back_to_back;
        @(negedge clk);
        peri_req = 1'b1; peri_write = 1'b0; peri_be = 4'h0; peri_addr = {27'h0, 3'd2, 2'b00};
        @(posedge clk);
        #1;
        n_checks++;
        if (peri_rvalid !== 1'b1 || peri_rdata !== 32'hFFFF_FFFF) begin
            n_fail++;
            $display("[TB] FAIL b2b_first: got rvalid=%b rdata=%h, want 1 ffffffff", peri_rvalid, peri_rdata);
        end
        @(negedge clk);
        peri_write = 1'b1; peri_be = 4'hF; peri_wdata = 32'h0000_0007; peri_addr = {27'h0, 3'd5, 2'b00};
        @(posedge clk);
        #1;
        n_checks++;
        if (peri_rvalid !== 1'b1 || peri_rdata !== 32'h0) begin
            n_fail++;
            $display("[TB] FAIL b2b_second: got rvalid=%b rdata=%h, want 1 00000000", peri_rvalid, peri_rdata);
        end
        @(negedge clk);
        peri_write = 1'b0; peri_be = 4'h0; peri_addr = {27'h0, 3'd5, 2'b00};
        @(posedge clk);
        #1;
        n_checks++;
        if (peri_rvalid !== 1'b1 || peri_rdata !== 32'h0000_0007) begin
            n_fail++;
            $display("[TB] FAIL b2b_third: got rvalid=%b rdata=%h, want 1 00000007", peri_rvalid, peri_rdata);
        end
        peri_req = 1'b0;
        @(posedge clk);
        #1;
        n_checks++;
        if (peri_rvalid !== 1'b0) begin
            n_fail++;
            $display("[TB] FAIL b2b_idle: got rvalid=%b, want 0", peri_rvalid);
        end
    endtask

    task automatic test_prescale;
        wr_reg(3'd5, 4'hF, 32'd3);
        wr_reg(3'd4, 4'hF, 32'd1);
        repeat (40) @(posedge clk);
        rd_reg(3'd0, rd);
        n_checks++;
        if (rd < 32'd9 || rd > 32'd11) begin
            n_fail++;
            $display("[TB] FAIL prescale_rate: got mtime_lo=%0d, want 10 +/- 1", rd);
        end
        wr_reg(3'd4, 4'hF, 32'd0);
    endtask

    task automatic test_carry_shadow;
        wr_reg(3'd0, 4'hF, 32'hFFFF_FFFE);
        wr_reg(3'd1, 4'hF, 32'h0);
        wr_reg(3'd5, 4'hF, 32'h0);
        wr_reg(3'd4, 4'hF, 32'd1);
        repeat (3) @(posedge clk);
        rd_reg(3'd0, rd);
        n_checks++;
        if (rd > 32'd2) begin
            n_fail++;
            $display("[TB] FAIL carry_lo: got %h, want about 00000001", rd);
        end
        repeat (8) @(posedge clk);
        rd_reg(3'd1, rd);
        n_checks++;
        if (rd !== 32'h1) begin
            n_fail++;
            $display("[TB] FAIL carry_hi: got %h, want 00000001", rd);
        end
        wr_reg(3'd1, 4'hF, 32'h7);
        rd_reg(3'd1, rd);
        n_checks++;
        if (rd !== 32'h1) begin
            n_fail++;
            $display("[TB] FAIL shadow_hold: got %h, want 00000001", rd);
        end
        rd_reg(3'd0, rd);
        rd_reg(3'd1, rd);
        n_checks++;
        if (rd !== 32'h7) begin
            n_fail++;
            $display("[TB] FAIL shadow_recapture: got %h, want 00000007", rd);
        end
        wr_reg(3'd4, 4'hF, 32'd0);
    endtask

    task automatic test_irq;
        int n;
        wr_reg(3'd0, 4'hF, 32'h0);
        wr_reg(3'd1, 4'hF, 32'h0);
        wr_reg(3'd2, 4'hF, 32'h20);
        wr_reg(3'd3, 4'hF, 32'h0);
        wr_reg(3'd4, 4'hF, 32'd3);
        n = 0;
        while (irq_timer_o !== 1'b1 && n < 40) begin
            @(posedge clk);
            #1;
            n++;
        end
        n_checks++;
        if (n != 33) begin
            n_fail++;
            $display("[TB] FAIL irq_rise_cycle: got %0d cycles after enable, want 33", n);
        end
        rd_reg(3'd6, rd);
        n_checks++;
        if (rd !== 32'h1) begin
            n_fail++;
            $display("[TB] FAIL status_hit: got %h, want 00000001", rd);
        end
        wr_reg(3'd2, 4'hF, 32'h1000);
        n_checks++;
        if (irq_timer_o !== 1'b1) begin
            n_fail++;
            $display("[TB] FAIL irq_lag: got %b right after cmp write, want 1", irq_timer_o);
        end
        @(posedge clk);
        #1;
        n_checks++;
        if (irq_timer_o !== 1'b0) begin
            n_fail++;
            $display("[TB] FAIL irq_fall: got %b, want 0", irq_timer_o);
        end
        rd_reg(3'd6, rd);
        n_checks++;
        if (rd !== 32'h0) begin
            n_fail++;
            $display("[TB] FAIL status_clear: got %h, want 00000000", rd);
        end
        wr_reg(3'd4, 4'hF, 32'd0);
    endtask

    task automatic test_byte_enable;
        wr_reg(3'd2, 4'hF, 32'hFFFF_FFFF);
        wr_reg(3'd2, 4'b0010, 32'hAABB_CCDD);
        rd_reg(3'd2, rd);
        n_checks++;
        if (rd !== 32'hFFFF_CCFF) begin
            n_fail++;
            $display("[TB] FAIL be_partial: got %h, want ffffccff", rd);
        end
        wr_reg(3'd3, 4'b0000, 32'h1234_5678);
        rd_reg(3'd3, rd);
        n_checks++;
        if (rd !== 32'h0) begin
            n_fail++;
            $display("[TB] FAIL be_zero: got %h, want 00000000", rd);
        end
        wr_reg(3'd5, 4'hF, 32'hFFFF_FFFF);
        rd_reg(3'd5, rd);
        n_checks++;
        if (rd !== 32'h0000_FFFF) begin
            n_fail++;
            $display("[TB] FAIL prescale_width: got %h, want 0000ffff", rd);
        end
        wr_reg(3'd4, 4'hF, 32'hFFFF_FFFE);
        rd_reg(3'd4, rd);
        n_checks++;
        if (rd !== 32'h2) begin
            n_fail++;
            $display("[TB] FAIL ctrl_bits: got %h, want 00000002", rd);
        end
        wr_reg(3'd4, 4'hF, 32'h0);
        wr_reg(3'd7, 4'hF, 32'h1234_5678);
        bus_op(1'b0, 3'd7, 4'h0, 32'h0, rd, g_seen, v_seen);
        n_checks++;
        if (rd !== 32'h0 || v_seen !== 1'b1) begin
            n_fail++;
            $display("[TB] FAIL unmapped: got rdata=%h rvalid=%b, want 00000000 1", rd, v_seen);
        end
    endtask

    task automatic test_simultaneous;
        wr_reg(3'd5, 4'hF, 32'd3);
        wr_reg(3'd0, 4'hF, 32'h0);
        wr_reg(3'd1, 4'hF, 32'h0);
        wr_reg(3'd4, 4'hF, 32'd1);
        repeat (7) @(posedge clk);
        wr_reg(3'd0, 4'hF, 32'd5);
        rd_reg(3'd0, rd);
        n_checks++;
        if (rd !== 32'd5) begin
            n_fail++;
            $display("[TB] FAIL write_beats_tick: got %0d, want 5", rd);
        end
        repeat (3) @(posedge clk);
        rd_reg(3'd0, rd);
        n_checks++;
        if (rd !== 32'd6) begin
            n_fail++;
            $display("[TB] FAIL after_write_tick: got %0d, want 6", rd);
        end
        rd_reg(3'd1, rd);
        n_checks++;
        if (rd !== 32'd0) begin
            n_fail++;
            $display("[TB] FAIL other_half_held: got %h, want 00000000", rd);
        end
    endtask

    task automatic test_reset_mid_txn;
        @(negedge clk);
        peri_req = 1'b1; peri_write = 1'b0; peri_be = 4'h0; peri_addr = {27'h0, 3'd2, 2'b00};
        @(posedge clk);
        #1;
        n_checks++;
        if (peri_rvalid !== 1'b1) begin
            n_fail++;
            $display("[TB] FAIL pre_reset_rvalid: got %b, want 1", peri_rvalid);
        end
        rst_n = 1'b0;
        #1;
        n_checks++;
        if (peri_rvalid !== 1'b0 || peri_rdata !== 32'h0) begin
            n_fail++;
            $display("[TB] FAIL reset_drops_rvalid: got rvalid=%b rdata=%h, want 0 00000000", peri_rvalid, peri_rdata);
        end
        peri_req = 1'b0;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        rd_reg(3'd2, rd);
        n_checks++;
        if (rd !== 32'hFFFF_FFFF) begin
            n_fail++;
            $display("[TB] FAIL cmp_after_reset: got %h, want ffffffff", rd);
        end
        rd_reg(3'd0, rd);
        n_checks++;
        if (rd !== 32'h0) begin
            n_fail++;
            $display("[TB] FAIL mtime_after_reset: got %h, want 00000000", rd);
        end
    endtask

    // Safety net so the run can never hang.
    initial begin
        #500000;
        $display("[TB] FAIL watchdog: simulation time limit reached, want completion");
        $fatal(1, "[TB] watchdog expired");
    end

    // Scenario sequence.
    initial begin
        n_checks = 0;
        n_fail   = 0;
        test_reset();
        test_back_to_back();
        wr_reg(3'd5, 4'hF, 32'h0);
        test_prescale();
        test_carry_shadow();
        test_irq();
        test_byte_enable();
        test_simultaneous();
        test_reset_mid_txn();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
